// File: rtl/multiplier.sv
// rtl/multiplier.sv - bit-serial GF(2)[x] multiplier modulo PQ for the masked GF(2^8) datapath
// Horner iteration, one coefficient of B per cycle, MSB first.
module multiplier #(
   parameter int         d  = 8,
   parameter logic [8+d:0] PQ = 17'h10001
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         drdy_i,
   input  logic [0:7+d] p1,
   input  logic [0:7+d] p2,
   output logic         drdy_o,
   output logic [0:7+d] out
);

   localparam int W  = 8 + d;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] C_LAST = CW'(W - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_acc;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    w_xacc;
   logic [W-1:0]    w_next;

   // Port vectors are [0:W-1] with index 0 as x^(W-1); copying into [W-1:0]
   // keeps the numeric value, so bit i of the internal registers is x^i.
   always_comb begin
      w_xacc = {r_acc[W-2:0], 1'b0} ^ (r_acc[W-1] ? PQ[W-1:0] : '0);
      w_next = w_xacc ^ (r_b[r_cnt] ? r_a : '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         out     <= '0;
         drdy_o  <= 1'b0;
      end else begin
         drdy_o <= 1'b0;
         case (r_state)
            IDLE: begin
               if (drdy_i) begin
                  r_a     <= p1;
                  r_b     <= p2;
                  r_acc   <= '0;
                  r_cnt   <= C_LAST;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_acc <= w_next;
               if (r_cnt == '0) begin
                  out     <= w_next;
                  drdy_o  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - scoreboard bench for the bit-serial GF(2)[x] multiplier
module tb_multiplier;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] v;
      int           c;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         drdy_i;
   logic [0:W-1] p1;
   logic [0:W-1] p2;
   logic         drdy_o;
   logic [0:W-1] out;

   exp_t         sb[$];
   int           total;
   int           bad;
   int           cyc;

   multiplier #(.d(8), .PQ(17'h10001)) dut (
      .clk    (clk),
      .rst    (rst),
      .drdy_i (drdy_i),
      .p1     (p1),
      .p2     (p2),
      .drdy_o (drdy_o),
      .out    (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every completion strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && drdy_o) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_strobe: drdy_o=1 at cycle %0d with nothing expected", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(out), 32'(e.v));
            check("latency", 32'(cyc), 32'(e.c));
         end
      end
   end

   // Called at posedge+1; the start is sampled at the next edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e, input bit expect_it);
      exp_t x;
      p1     = a;
      p2     = b;
      drdy_i = 1'b1;
      x.v = e;
      x.c = cyc + 1 + W;
      if (expect_it) sb.push_back(x);
      @(posedge clk); #1;
      drdy_i = 1'b0;
      p1     = W'($urandom);
      p2     = W'($urandom);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   logic [W-1:0] va[7];
   logic [W-1:0] vb[7];
   logic [W-1:0] ve[7];

   initial begin
      int t0;
      int done1;
      total  = 0;
      bad    = 0;
      rst    = 1'b0;
      drdy_i = 1'b0;
      p1     = '0;
      p2     = '0;

      va[0] = 16'h0001; vb[0] = 16'h0001; ve[0] = 16'h0001;
      va[1] = 16'h8000; vb[1] = 16'h0002; ve[1] = 16'h0001;
      va[2] = 16'h1234; vb[2] = 16'h0010; ve[2] = 16'h2341;
      va[3] = 16'h0003; vb[3] = 16'h0003; ve[3] = 16'h0005;
      va[4] = 16'hFFFF; vb[4] = 16'h0001; ve[4] = 16'hFFFF;
      va[5] = 16'h0000; vb[5] = 16'hABCD; ve[5] = 16'h0000;
      va[6] = 16'h00A5; vb[6] = 16'h0100; ve[6] = 16'hA500;

      repeat (2) @(posedge clk);
      #1;
      check("reset_out", 32'(out), 32'h0);
      check("reset_drdy", 32'(drdy_o), 32'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_drdy", 32'(drdy_o), 32'h0);

      for (int i = 0; i < 7; i++) begin
         issue(va[i], vb[i], ve[i], 1'b1);
         repeat (W + 2) @(posedge clk);
         #1;
         check("hold_out", 32'(out), 32'(ve[i]));
      end

      // Start ignored while busy, then a start in the drdy_o cycle.
      t0 = cyc;
      issue(16'h1234, 16'h0010, 16'h2341, 1'b1);
      done1 = t0 + 1 + W;
      repeat (4) @(posedge clk);
      #1;
      issue(16'h5555, 16'h0003, 16'h0000, 1'b0);
      wait_until(done1);
      check("drdy_window", 32'(drdy_o), 32'h1);
      issue(16'h0003, 16'h0005, 16'h000F, 1'b1);
      repeat (W + 2) @(posedge clk);
      #1;

      // Abort by reset at cycle 5 of an operation.
      issue(16'h7777, 16'h7777, 16'h0000, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_out", 32'(out), 32'h0);
      check("abort_drdy", 32'(drdy_o), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (W + 4) @(posedge clk);
      #1;
      check("post_abort_out", 32'(out), 32'h0);
      issue(16'h0002, 16'h0004, 16'h0008, 1'b1);

      t0 = cyc;
      while (sb.size() != 0 && cyc < t0 + 4 * W) begin
         @(posedge clk); #1;
      end
      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      check("final_out", 32'(out), 32'h0008);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
